// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM states and CPOL/CPHA mode encodings.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD
    } state_t;

    // Mode encoding is {cpol, cpha}
    typedef logic [1:0] spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = 2'b00;
    localparam spi_mode_t SPI_MODE1 = 2'b01;
    localparam spi_mode_t SPI_MODE2 = 2'b10;
    localparam spi_mode_t SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period timer: pulses tick_c once every div+1 cycles, held at zero while clear is high.
module spi_sck_gen #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick_c
);

    logic [DIV_WIDTH-1:0] cnt;

    // cnt never exceeds div, so the increment cannot wrap
    assign tick_c = !clear && (cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, CPOL/CPHA modes, runtime SCK divider, NUM_CS chip selects.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input for LSB-first shifting.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  NUM_CS     = 4,
    parameter int unsigned  DIV_WIDTH  = 8,
    localparam int unsigned CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  new_data,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int unsigned    EW        = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    state_t                  state;
    spi_mode_t               mode_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [DATA_WIDTH-1:0]   tx_sr;
    logic [DATA_WIDTH-1:0]   rx_sr;
    logic [EW-1:0]           edge_cnt;
    logic                    tick_c;
    logic                    sample_c;
    logic                    lsb_c;
    logic                    lsb_in_c;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                        input logic lsb);
        return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // LSB-first fills from the top so the finished word is in natural bit order
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                       input logic b, input logic lsb);
        return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] d;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            d[i] = (sel != CS_W'(i));
        end
        return d;
    endfunction

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else if (state == IDLE && start) begin
            lsb_q <= lsb_first;
        end
    end

    assign lsb_c    = lsb_q;
    assign lsb_in_c = lsb_first;
`else
    assign lsb_c    = 1'b0;
    assign lsb_in_c = 1'b0;
`endif

    spi_sck_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sck_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .div    (div_q),
        .tick_c (tick_c)
    );

    // Even edge count = leading edge; CPHA picks whether that edge samples or shifts
    always_comb begin
        sample_c = 1'b0;
        unique case (mode_q)
            SPI_MODE0, SPI_MODE2: sample_c = ~edge_cnt[0];
            SPI_MODE1, SPI_MODE3: sample_c = edge_cnt[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            busy     <= 1'b0;
            new_data <= 1'b0;
            data_out <= '0;
            mode_q   <= SPI_MODE0;
            div_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
        end else begin
            new_data <= 1'b0;
            case (state)
                IDLE: begin
                    sck <= cpol;
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        mode_q   <= {cpol, cpha};
                        div_q    <= clk_div;
                        cs_n     <= cs_decode(cs_sel);
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                        if (cpha) begin
                            tx_sr <= data_in;
                        end else begin
                            mosi  <= out_bit(data_in, lsb_in_c);
                            tx_sr <= shift_out(data_in, lsb_in_c);
                        end
                    end
                end
                SETUP: begin
                    if (tick_c) state <= TRANSFER;
                end
                TRANSFER: begin
                    if (tick_c) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (sample_c) begin
                            rx_sr <= shift_in(rx_sr, miso, lsb_c);
                        end else begin
                            mosi  <= out_bit(tx_sr, lsb_c);
                            tx_sr <= shift_out(tx_sr, lsb_c);
                        end
                        if (edge_cnt == LAST_EDGE) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick_c) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cs_n     <= '1;
                        data_out <= rx_sr;
                        new_data <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed self-checking bench for spi_master_cfg: loopback and pattern slave, all modes, CS decode,
// back-to-back starts, async reset abort and, with SPI_LSB_FIRST_EN, LSB-first shifting.
module tb_spi_master_cfg;

    localparam int unsigned DW  = 16;
    localparam int unsigned NCS = 5;
    localparam int unsigned DVW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     cs_sel;
    logic           cpol;
    logic           cpha;
    logic [DVW-1:0] clk_div;
    logic [DW-1:0]  data_in;
    logic [DW-1:0]  data_out;
    logic           busy;
    logic           new_data;
    logic           miso;
    logic           mosi;
    logic           sck;
    logic [NCS-1:0] cs_n;
`ifdef SPI_LSB_FIRST_EN
    logic           lsb_first;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_master_cfg #(
        .DATA_WIDTH (DW),
        .NUM_CS     (NCS),
        .DIV_WIDTH  (DVW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
        .data_in   (data_in),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .data_out  (data_out),
        .busy      (busy),
        .new_data  (new_data),
        .miso      (miso),
        .mosi      (mosi),
        .sck       (sck),
        .cs_n      (cs_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave: loopback, or a fixed pattern that changes on the mode's shift edge
    logic        loop;
    logic [15:0] pat;
    logic        pat_bit;
    logic        sck_seen;
    int          se = 0;
    int          bidx;

    always @(sck or cs_n) begin
        if (&cs_n) se = 0;
        else if (sck !== sck_seen) se++;
        sck_seen = sck;
    end

    always @* begin
        bidx = cpha ? ((se == 0) ? 0 : (se - 1) / 2) : se / 2;
        if (bidx > 15) bidx = 15;
        pat_bit = pat[15 - bidx];
    end

    assign miso = loop ? mosi : pat_bit;

    // Free-running monitors sampled on the falling edge; tests take differences
    int   cyc = 0, busy_cyc = 0, nd_cnt = 0, bedges = 0;
    int   last_edge_cyc = 0, last_gap = 0, hi_run = 0, last_hi_run = 0;
    logic sck_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cyc++;
        if (new_data) nd_cnt++;
        if (busy && (sck !== sck_prev)) begin
            bedges++;
            last_gap      = cyc - last_edge_cyc;
            last_edge_cyc = cyc;
        end
        sck_prev = sck;
        if (&cs_n) hi_run++;
        else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
    end

    task automatic launch(input logic pol, input logic pha, input logic [DVW-1:0] div,
                          input logic [2:0] sel, input logic [DW-1:0] d);
        cpol    = pol;
        cpha    = pha;
        clk_div = div;
        cs_sel  = sel;
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!new_data && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, 32'(new_data), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0, e0, n0;
        logic [1:0] mm;

        rst = 1'b1; start = 1'b0; cs_sel = 3'd0; cpol = 1'b0; cpha = 1'b0;
        clk_div = '0; data_in = '0; loop = 1'b1; pat = 16'h0000;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("rst_sck",      32'(sck),      32'd0);
        check("rst_mosi",     32'(mosi),     32'd0);
        check("rst_cs_n",     32'(cs_n),     32'h1f);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_new_data", 32'(new_data), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Mode 0, H=1 loopback
        b0 = busy_cyc; e0 = bedges; n0 = nd_cnt;
        launch(1'b0, 1'b0, 8'd0, 3'd0, 16'hA55A);
        wait_done("t1");
        check("t1_data",  32'(data_out), 32'hA55A);
        check("t1_cs_n",  32'(cs_n),     32'h1f);
        check("t1_busy",  32'(busy),     32'd0);
        repeat (3) @(negedge clk);
        check("t1_busy_cycles", 32'(busy_cyc - b0), 32'd34);
        check("t1_sck_edges",   32'(bedges - e0),   32'd32);
        check("t1_pulses",      32'(nd_cnt - n0),   32'd1);
        @(posedge clk);
        #1;

        // Modes 1..3, H=4, pattern slave
        loop = 1'b0;
        pat  = 16'h1234;
        for (int m = 1; m < 4; m++) begin
            mm   = 2'(m);
            cpol = mm[1];
            cpha = mm[0];
            repeat (3) @(posedge clk);
            #1;
            check("t2_idle_sck", 32'(sck), 32'(mm[1]));
            b0 = busy_cyc; e0 = bedges;
            launch(mm[1], mm[0], 8'd3, 3'd0, 16'hFFFF);
            wait_done("t2");
            check("t2_data", 32'(data_out), 32'h1234);
            check("t2_half_period", 32'(last_gap), 32'd4);
            repeat (2) @(negedge clk);
            check("t2_sck_edges",   32'(bedges - e0),   32'd32);
            check("t2_busy_cycles", 32'(busy_cyc - b0), 32'd136);
            @(posedge clk);
            #1;
            check("t2_end_sck", 32'(sck), 32'(mm[1]));
        end

        // Chip-select decode, in range and out of range
        loop = 1'b1;
        launch(1'b0, 1'b0, 8'd0, 3'd2, 16'h00FF);
        repeat (5) @(posedge clk);
        #1;
        check("t3_cs2", 32'(cs_n), 32'b11011);
        wait_done("t3a");
        check("t3_data_a", 32'(data_out), 32'h00FF);
        @(posedge clk);
        #1;
        launch(1'b0, 1'b0, 8'd0, 3'd5, 16'h0F0F);
        repeat (5) @(posedge clk);
        #1;
        check("t3_cs5", 32'(cs_n), 32'b11111);
        wait_done("t3b");
        check("t3_data_b", 32'(data_out), 32'h0F0F);
        @(posedge clk);
        #1;

        // start held high: back-to-back, data_in changes while busy ignored
        n0 = nd_cnt; b0 = busy_cyc;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; cs_sel = 3'd1; data_in = 16'h1357;
        start = 1'b1;
        @(posedge clk);
        #1;
        data_in = 16'h2468;
        repeat (10) @(posedge clk);
        #1;
        data_in = 16'hC3C3;
        wait_done("t4a");
        check("t4_data_a", 32'(data_out), 32'h1357);
        @(posedge clk);
        #1;
        check("t4_b2b_busy", 32'(busy), 32'd1);
        wait_done("t4b");
        start = 1'b0;
        check("t4_data_b", 32'(data_out), 32'hC3C3);
        repeat (40) @(negedge clk);
        check("t4_pulses",      32'(nd_cnt - n0),   32'd2);
        check("t4_busy_cycles", 32'(busy_cyc - b0), 32'd68);
        check("t4_cs_gap",      32'(last_hi_run),   32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of TRANSFER
        n0 = nd_cnt;
        launch(1'b1, 1'b0, 8'd3, 3'd0, 16'hBEEF);
        repeat (20) @(posedge clk);
        #3;
        check("t5_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_sck",      32'(sck),      32'd0);
        check("t5_mosi",     32'(mosi),     32'd0);
        check("t5_cs_n",     32'(cs_n),     32'h1f);
        check("t5_busy",     32'(busy),     32'd0);
        check("t5_new_data", 32'(new_data), 32'd0);
        check("t5_data_out", 32'(data_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (150) @(negedge clk);
        check("t5_no_pulse", 32'(nd_cnt - n0), 32'd0);
        check("t5_idle_sck", 32'(sck),         32'd1);
        @(posedge clk);
        #1;

`ifdef SPI_LSB_FIRST_EN
        // LSB-first shifting with loopback
        lsb_first = 1'b1;
        launch(1'b0, 1'b0, 8'd1, 3'd0, 16'h0001);
        check("t6_first_mosi", 32'(mosi), 32'd1);
        wait_done("t6");
        check("t6_data", 32'(data_out), 32'h0001);
        lsb_first = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
